// File: rtl/ctrl_pkg.sv
// Shared types and constants for the WISC-SP13 pipelined control unit.
package ctrl_pkg;

    localparam int OPC_BITS   = 5;
    localparam int ALUOP_BITS = 4;

    // Opcodes, grouped the way the decoder treats them.
    localparam logic [4:0] OPC_HALT   = 5'b00000;
    localparam logic [4:0] OPC_NOP    = 5'b00001;
    localparam logic [4:0] OPC_ILL0   = 5'b00010;
    localparam logic [4:0] OPC_ILL1   = 5'b00011;
    localparam logic [4:0] OPC_J      = 5'b00100;
    localparam logic [4:0] OPC_JR     = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b00110;
    localparam logic [4:0] OPC_JALR   = 5'b00111;
    localparam logic [4:0] OPC_ADDI   = 5'b01000;
    localparam logic [4:0] OPC_SUBI   = 5'b01001;
    localparam logic [4:0] OPC_XORI   = 5'b01010;
    localparam logic [4:0] OPC_ANDNI  = 5'b01011;
    localparam logic [4:0] OPC_BEQZ   = 5'b01100;
    localparam logic [4:0] OPC_BNEZ   = 5'b01101;
    localparam logic [4:0] OPC_BLTZ   = 5'b01110;
    localparam logic [4:0] OPC_BGEZ   = 5'b01111;
    localparam logic [4:0] OPC_ST     = 5'b10000;
    localparam logic [4:0] OPC_LD     = 5'b10001;
    localparam logic [4:0] OPC_SLBI   = 5'b10010;
    localparam logic [4:0] OPC_STU    = 5'b10011;
    localparam logic [4:0] OPC_ROLI   = 5'b10100;
    localparam logic [4:0] OPC_SLLI   = 5'b10101;
    localparam logic [4:0] OPC_RORI   = 5'b10110;
    localparam logic [4:0] OPC_SRLI   = 5'b10111;
    localparam logic [4:0] OPC_LBI    = 5'b11000;
    localparam logic [4:0] OPC_BTR    = 5'b11001;
    localparam logic [4:0] OPC_RSHIFT = 5'b11010;
    localparam logic [4:0] OPC_RARITH = 5'b11011;
    localparam logic [4:0] OPC_SEQ    = 5'b11100;
    localparam logic [4:0] OPC_SLT    = 5'b11101;
    localparam logic [4:0] OPC_SLE    = 5'b11110;
    localparam logic [4:0] OPC_SCO    = 5'b11111;

    // Full control word carried in the X stage (17 fields).
    typedef struct packed {
        logic                  Halt;
        logic                  Jump;
        logic                  JumpR;
        logic                  Branch;
        logic                  RegWrite;
        logic [1:0]            RegDst;
        logic [ALUOP_BITS-1:0] AluOp;
        logic                  AluSrc;
        logic                  AluSrc2;
        logic                  AluSrc3;
        logic                  AluSpecSel2;
        logic [1:0]            AluSpecSel1;
        logic [1:0]            ImmSel;
        logic                  MemRead;
        logic                  MemWrite;
        logic                  MemToReg;
        logic                  SLBIExt;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '0;

    // Later stages only carry the fields still consumed downstream.
    typedef struct packed {
        logic       halt;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
    } m_stage_t;

    typedef struct packed {
        logic       halt;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
    } w_stage_t;

    localparam m_stage_t M_ZERO = '0;
    localparam w_stage_t W_ZERO = '0;

    function automatic m_stage_t to_m_stage(input ctrl_t c);
        m_stage_t m;
        m.halt       = c.Halt;
        m.reg_write  = c.RegWrite;
        m.reg_dst    = c.RegDst;
        m.mem_read   = c.MemRead;
        m.mem_write  = c.MemWrite;
        m.mem_to_reg = c.MemToReg;
        return m;
    endfunction

endpackage

// File: rtl/ctrl_pipe_decode.sv
// Combinational opcode decoder: opcode -> control word plus illegal flag.
import ctrl_pkg::*;

module ctrl_decode #(
    parameter int ILLEGAL_TRAP = 0,
    parameter int OPC_W        = 5
) (
    input  logic [OPC_W-1:0] i_opcode,
    output ctrl_t            o_ctrl,
    output logic             o_illegal
);

    // Decode table; every field not set by an opcode stays 0.
    always_comb begin
        o_ctrl    = CTRL_ZERO;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_HALT: o_ctrl.Halt = 1'b1;
            OPC_NOP: ;
            OPC_ILL0, OPC_ILL1: begin
                o_illegal   = 1'b1;
                o_ctrl.Halt = (ILLEGAL_TRAP != 0);
            end
            OPC_J:  o_ctrl.Jump = 1'b1;
            OPC_JR: begin
                o_ctrl.Jump  = 1'b1;
                o_ctrl.JumpR = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                o_ctrl.Jump     = 1'b1;
                o_ctrl.JumpR    = i_opcode[0];
                o_ctrl.RegWrite = 1'b1;
                o_ctrl.RegDst   = 2'b11;
                o_ctrl.AluOp    = 4'b1110;
                o_ctrl.AluSrc2  = 1'b1;
                o_ctrl.AluSrc3  = 1'b1;
            end
            OPC_ADDI, OPC_SUBI, OPC_XORI, OPC_ANDNI: begin
                o_ctrl.RegWrite    = 1'b1;
                o_ctrl.AluSrc      = 1'b1;
                o_ctrl.AluOp       = 4'b0100;
                o_ctrl.AluSpecSel2 = 1'b1;
                o_ctrl.AluSpecSel1 = i_opcode[1:0];
                o_ctrl.ImmSel      = i_opcode[1] ? 2'b01 : 2'b10;
            end
            OPC_BEQZ, OPC_BNEZ, OPC_BLTZ, OPC_BGEZ: begin
                o_ctrl.Branch = 1'b1;
                o_ctrl.AluOp  = 4'b0110 + {2'b00, i_opcode[1:0]};
            end
            OPC_ST, OPC_LD, OPC_STU: begin
                o_ctrl.AluSrc      = 1'b1;
                o_ctrl.AluOp       = 4'b0100;
                o_ctrl.ImmSel      = 2'b10;
                o_ctrl.AluSpecSel2 = 1'b1;
                if (i_opcode == OPC_LD) begin
                    o_ctrl.MemRead  = 1'b1;
                    o_ctrl.MemToReg = 1'b1;
                    o_ctrl.RegWrite = 1'b1;
                end else begin
                    o_ctrl.MemWrite = 1'b1;
                end
                if (i_opcode == OPC_STU) begin
                    o_ctrl.RegWrite = 1'b1;
                    o_ctrl.RegDst   = 2'b01;
                end
            end
            OPC_SLBI: begin
                o_ctrl.RegDst   = 2'b01;
                o_ctrl.RegWrite = 1'b1;
                o_ctrl.AluSrc   = 1'b1;
                o_ctrl.AluOp    = 4'b0010;
                o_ctrl.SLBIExt  = 1'b1;
            end
            OPC_ROLI, OPC_SLLI, OPC_RORI, OPC_SRLI: begin
                o_ctrl.RegWrite    = 1'b1;
                o_ctrl.AluSrc      = 1'b1;
                o_ctrl.AluOp       = 4'b0101;
                o_ctrl.ImmSel      = 2'b11;
                o_ctrl.AluSpecSel2 = 1'b1;
                o_ctrl.AluSpecSel1 = i_opcode[1:0];
            end
            OPC_LBI: begin
                o_ctrl.RegDst   = 2'b01;
                o_ctrl.RegWrite = 1'b1;
                o_ctrl.AluSrc   = 1'b1;
                o_ctrl.AluOp    = 4'b0001;
            end
            OPC_BTR, OPC_RSHIFT, OPC_RARITH, OPC_SEQ, OPC_SLT, OPC_SLE, OPC_SCO: begin
                o_ctrl.RegDst   = 2'b10;
                o_ctrl.RegWrite = 1'b1;
                case (i_opcode)
                    OPC_BTR:    o_ctrl.AluOp = 4'b0011;
                    OPC_RSHIFT: o_ctrl.AluOp = 4'b0101;
                    OPC_RARITH: o_ctrl.AluOp = 4'b0100;
                    OPC_SEQ:    o_ctrl.AluOp = 4'b1011;
                    OPC_SLT:    o_ctrl.AluOp = 4'b1100;
                    OPC_SLE:    o_ctrl.AluOp = 4'b1101;
                    default:    o_ctrl.AluOp = 4'b1010;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: decodes D and carries control through X, M and W,
// tracking sticky halt and illegal-opcode state.
//
// Stage protocol: each stage register pairs a valid bit with its payload.
// valid=1 means the payload is a live instruction; valid=0 is a bubble and
// its payload is held at 0. There is no ready: X accepts D only when
// d_valid & !stall & !flush & !halt_pending, while M and W always advance.
import ctrl_pkg::*;

module ctrl_pipe #(
    parameter int ILLEGAL_TRAP = 0,
    parameter int OPC_W        = 5,
    parameter int ALUOP_W      = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_d_valid,
    input  logic [OPC_W-1:0] i_d_opcode,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic             o_x_valid,
    output logic             o_m_valid,
    output logic             o_w_valid,
    output ctrl_t            o_x_ctrl,
    output logic             o_m_MemRead,
    output logic             o_m_MemWrite,
    output logic             o_m_MemToReg,
    output logic             o_w_RegWrite,
    output logic [1:0]       o_w_RegDst,
    output logic             o_w_MemToReg,
    output logic             o_halt_pending,
    output logic             o_halted,
    output logic             o_illegal
);

    // Only the 5-bit opcode / 4-bit AluOp encoding exists.
    if (OPC_W != OPC_BITS || ALUOP_W != ALUOP_BITS) begin : g_bad_width
        $error("ctrl_pipe: OPC_W must be 5 and ALUOP_W must be 4");
    end

    ctrl_t    w_d_ctrl;
    logic     w_d_illegal;
    logic     w_cap;

    logic     r_x_valid;
    ctrl_t    r_x_ctrl;
    logic     r_m_valid;
    m_stage_t r_m;
    logic     r_w_valid;
    w_stage_t r_w;
    logic     r_halt_pending;
    logic     r_halted;
    logic     r_illegal;

    ctrl_decode #(
        .ILLEGAL_TRAP (ILLEGAL_TRAP),
        .OPC_W        (OPC_W)
    ) u_decode (
        .i_opcode  (i_d_opcode),
        .o_ctrl    (w_d_ctrl),
        .o_illegal (w_d_illegal)
    );

    // flush outranks stall; once a halt is in flight nothing younger enters.
    assign w_cap = i_d_valid & ~i_stall & ~i_flush & ~r_halt_pending;

    // X stage: capture the decoded word or insert a bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x_valid <= 1'b0;
            r_x_ctrl  <= CTRL_ZERO;
        end else begin
            r_x_valid <= w_cap;
            r_x_ctrl  <= w_cap ? w_d_ctrl : CTRL_ZERO;
        end
    end

    // M and W stages: unconditional advance, never stalled or flushed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_m_valid <= 1'b0;
            r_m       <= M_ZERO;
            r_w_valid <= 1'b0;
            r_w       <= W_ZERO;
        end else begin
            r_m_valid <= r_x_valid;
            r_m       <= r_x_valid ? to_m_stage(r_x_ctrl) : M_ZERO;
            r_w_valid <= r_m_valid;
            r_w       <= r_m_valid ? '{halt: r_m.halt, reg_write: r_m.reg_write,
                                       reg_dst: r_m.reg_dst, mem_to_reg: r_m.mem_to_reg}
                                   : W_ZERO;
        end
    end

    // Sticky processor state: halt in flight, halted, illegal seen.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_halt_pending <= 1'b0;
            r_halted       <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            r_halt_pending <= r_halt_pending | (w_cap & w_d_ctrl.Halt);
            r_halted       <= r_halted | (r_w_valid & r_w.halt);
            r_illegal      <= r_illegal | (w_cap & w_d_illegal);
        end
    end

    // Outputs gated by their stage valid bit.
    always_comb begin
        o_x_valid      = r_x_valid;
        o_m_valid      = r_m_valid;
        o_w_valid      = r_w_valid;
        o_x_ctrl       = r_x_valid ? r_x_ctrl : CTRL_ZERO;
        o_m_MemRead    = r_m_valid & r_m.mem_read;
        o_m_MemWrite   = r_m_valid & r_m.mem_write;
        o_m_MemToReg   = r_m_valid & r_m.mem_to_reg;
        o_w_RegWrite   = r_w_valid & r_w.reg_write;
        o_w_RegDst     = r_w_valid ? r_w.reg_dst : 2'b00;
        o_w_MemToReg   = r_w_valid & r_w.mem_to_reg;
        o_halt_pending = r_halt_pending;
        o_halted       = r_halted;
        o_illegal      = r_illegal;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: table-driven decode/throughput vectors plus directed
// sequences for stall, flush, halt, illegal trap and asynchronous reset.
import ctrl_pkg::*;

module tb_ctrl_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       d_valid = 1'b0;
    logic [4:0] d_opcode = 5'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;

    logic  x_valid, m_valid, w_valid, m_rd, m_wr, m_m2r, w_rw, w_m2r, hp, hd, il;
    logic  [1:0] w_rd;
    ctrl_t x_ctrl;
    logic  t_x_valid, t_m_valid, t_w_valid, t_m_rd, t_m_wr, t_m_m2r, t_w_rw, t_w_m2r, t_hp, t_hd, t_il;
    logic  [1:0] t_w_rd;
    ctrl_t t_x_ctrl;

    ctrl_pipe #(.ILLEGAL_TRAP(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_d_valid(d_valid), .i_d_opcode(d_opcode),
        .i_stall(stall), .i_flush(flush),
        .o_x_valid(x_valid), .o_m_valid(m_valid), .o_w_valid(w_valid), .o_x_ctrl(x_ctrl),
        .o_m_MemRead(m_rd), .o_m_MemWrite(m_wr), .o_m_MemToReg(m_m2r),
        .o_w_RegWrite(w_rw), .o_w_RegDst(w_rd), .o_w_MemToReg(w_m2r),
        .o_halt_pending(hp), .o_halted(hd), .o_illegal(il)
    );

    ctrl_pipe #(.ILLEGAL_TRAP(1)) dut_t (
        .i_clk(clk), .i_rst(rst), .i_d_valid(d_valid), .i_d_opcode(d_opcode),
        .i_stall(stall), .i_flush(flush),
        .o_x_valid(t_x_valid), .o_m_valid(t_m_valid), .o_w_valid(t_w_valid), .o_x_ctrl(t_x_ctrl),
        .o_m_MemRead(t_m_rd), .o_m_MemWrite(t_m_wr), .o_m_MemToReg(t_m_m2r),
        .o_w_RegWrite(t_w_rw), .o_w_RegDst(t_w_rd), .o_w_MemToReg(t_w_m2r),
        .o_halt_pending(t_hp), .o_halted(t_hd), .o_illegal(t_il)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dv, input logic [4:0] opc, input logic st, input logic fl);
        d_valid  = dv;
        d_opcode = opc;
        stall    = st;
        flush    = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       dv;
        logic [4:0] opc;
        logic       st;
        logic       fl;
        logic       xv;
        ctrl_t      ctrl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic dv, input logic [4:0] opc, input logic st,
                                input logic fl, input logic xv, input ctrl_t c);
        vec_t v;
        v.dv = dv; v.opc = opc; v.st = st; v.fl = fl; v.xv = xv; v.ctrl = c;
        vecs.push_back(v);
    endfunction

    ctrl_t c;
    ctrl_t c_add;
    ctrl_t pm;
    ctrl_t pw;
    logic  pmv;
    logic  pwv;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        do_reset();
        chk("rst x_valid", x_valid, 0);
        chk("rst m_valid", m_valid, 0);
        chk("rst w_valid", w_valid, 0);
        chk("rst x_ctrl", x_ctrl, 0);
        chk("rst halt_pending", hp, 0);
        chk("rst halted", hd, 0);
        chk("rst illegal", il, 0);

        // ---- hand-computed decode table, applied back to back ----
        c = CTRL_ZERO; c.RegWrite = 1; c.AluSrc = 1; c.AluOp = 4'b0100; c.AluSpecSel2 = 1;
        c.ImmSel = 2'b10;                                   add(1, 5'b01000, 0, 0, 1, c); // ADDI
        c = CTRL_ZERO; c.RegWrite = 1; c.AluSrc = 1; c.AluOp = 4'b0100; c.AluSpecSel2 = 1;
        c.AluSpecSel1 = 2'b10; c.ImmSel = 2'b01;            add(1, 5'b01010, 0, 0, 1, c); // XORI
        c = CTRL_ZERO; c.Jump = 1; c.RegWrite = 1; c.RegDst = 2'b11; c.AluOp = 4'b1110;
        c.AluSrc2 = 1; c.AluSrc3 = 1;                       add(1, 5'b00110, 0, 0, 1, c); // JAL
        c.JumpR = 1;                                        add(1, 5'b00111, 0, 0, 1, c); // JALR
        c = CTRL_ZERO; c.Jump = 1; c.JumpR = 1;             add(1, 5'b00101, 0, 0, 1, c); // JR
        c = CTRL_ZERO; c.Branch = 1; c.AluOp = 4'b1001;     add(1, 5'b01111, 0, 0, 1, c); // BGEZ
        c = CTRL_ZERO; c.MemWrite = 1; c.AluSrc = 1; c.AluOp = 4'b0100; c.ImmSel = 2'b10;
        c.AluSpecSel2 = 1;                                  add(1, 5'b10000, 0, 0, 1, c); // ST
        c = CTRL_ZERO; c.MemRead = 1; c.MemToReg = 1; c.RegWrite = 1; c.AluSrc = 1;
        c.AluOp = 4'b0100; c.ImmSel = 2'b10; c.AluSpecSel2 = 1;
                                                            add(1, 5'b10001, 0, 0, 1, c); // LD
        c = CTRL_ZERO; c.MemWrite = 1; c.RegWrite = 1; c.RegDst = 2'b01; c.AluSrc = 1;
        c.AluOp = 4'b0100; c.ImmSel = 2'b10; c.AluSpecSel2 = 1;
                                                            add(1, 5'b10011, 0, 0, 1, c); // STU
        c = CTRL_ZERO;                                      add(1, 5'b11011, 1, 0, 0, c); // stalled
        c = CTRL_ZERO; c.RegDst = 2'b01; c.RegWrite = 1; c.AluSrc = 1; c.AluOp = 4'b0010;
        c.SLBIExt = 1;                                      add(1, 5'b10010, 0, 0, 1, c); // SLBI
        c = CTRL_ZERO; c.RegWrite = 1; c.AluSrc = 1; c.AluOp = 4'b0101; c.ImmSel = 2'b11;
        c.AluSpecSel2 = 1; c.AluSpecSel1 = 2'b01;           add(1, 5'b10101, 0, 0, 1, c); // SLLI
        c = CTRL_ZERO;                                      add(1, 5'b10001, 0, 1, 0, c); // flushed
        c = CTRL_ZERO; c.RegDst = 2'b01; c.RegWrite = 1; c.AluSrc = 1; c.AluOp = 4'b0001;
                                                            add(1, 5'b11000, 0, 0, 1, c); // LBI
        c = CTRL_ZERO; c.RegDst = 2'b10; c.RegWrite = 1; c.AluOp = 4'b0011;
                                                            add(1, 5'b11001, 0, 0, 1, c); // BTR
        c = CTRL_ZERO;                                      add(0, 5'b10001, 0, 0, 0, c); // idle
        c = CTRL_ZERO; c.RegDst = 2'b10; c.RegWrite = 1; c.AluOp = 4'b1100;
                                                            add(1, 5'b11101, 0, 0, 1, c); // SLT
        c = CTRL_ZERO; c.RegDst = 2'b10; c.RegWrite = 1; c.AluOp = 4'b1010;
                                                            add(1, 5'b11111, 0, 0, 1, c); // SCO
        c = CTRL_ZERO;                                      add(1, 5'b00001, 0, 0, 1, c); // NOP
        c = CTRL_ZERO;                                      add(1, 5'b00011, 0, 0, 1, c); // illegal
        c = CTRL_ZERO;                                      add(0, 5'b00000, 0, 0, 0, c); // drain
        c = CTRL_ZERO;                                      add(0, 5'b00000, 0, 0, 0, c); // drain

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].dv, vecs[i].opc, vecs[i].st, vecs[i].fl);
            tick();
            pmv = (i >= 1) ? vecs[i-1].xv : 1'b0;
            pm  = (i >= 1) ? vecs[i-1].ctrl : CTRL_ZERO;
            pwv = (i >= 2) ? vecs[i-2].xv : 1'b0;
            pw  = (i >= 2) ? vecs[i-2].ctrl : CTRL_ZERO;
            chk($sformatf("v%0d x_valid", i), x_valid, vecs[i].xv);
            chk($sformatf("v%0d x_ctrl", i), x_ctrl, vecs[i].ctrl);
            chk($sformatf("v%0d m_valid", i), m_valid, pmv);
            chk($sformatf("v%0d m_mem", i), {m_rd, m_wr, m_m2r},
                {pm.MemRead, pm.MemWrite, pm.MemToReg});
            chk($sformatf("v%0d w_valid", i), w_valid, pwv);
            chk($sformatf("v%0d w_ctrl", i), {w_rw, w_rd, w_m2r},
                {pw.RegWrite, pw.RegDst, pw.MemToReg});
        end
        chk("table illegal sticky", il, 1);
        chk("table no halt_pending", hp, 0);
        chk("table not halted", hd, 0);

        c_add = CTRL_ZERO; c_add.RegDst = 2'b10; c_add.RegWrite = 1; c_add.AluOp = 4'b0100;

        // ---- LD then one stall cycle ----
        do_reset();
        drive(1, 5'b10001, 0, 0); tick();
        chk("ld x_ctrl.MemRead", x_ctrl.MemRead, 1);
        drive(1, 5'b11011, 1, 0); tick();
        chk("ld stall bubble", x_valid, 0);
        chk("ld m_MemRead", m_rd, 1);
        drive(1, 5'b11011, 0, 0); tick();
        chk("ld stalled enters", x_valid, 1);
        chk("ld stalled ctrl", x_ctrl, c_add);
        chk("ld m bubble", m_valid, 0);
        chk("ld w regwrite", {w_valid, w_rw, w_m2r, w_rd}, {3'b111, 2'b00});
        drive(1, 5'b11011, 1, 0); tick();
        drive(1, 5'b11011, 1, 0); tick();
        chk("back-to-back stall", x_valid, 0);
        chk("stall drain m", m_valid, 0);

        // ---- branch in X flushes JAL in D ----
        do_reset();
        drive(1, 5'b01100, 0, 0); tick();
        chk("br x_ctrl.Branch", x_ctrl.Branch, 1);
        drive(1, 5'b00110, 0, 1); tick();
        chk("flush jal x_valid", x_valid, 0);
        chk("flush m_valid br", m_valid, 1);
        drive(0, 5'b0, 0, 0); tick();
        chk("br w_valid", w_valid, 1);
        chk("br w_RegWrite", w_rw, 0);
        tick();
        chk("jal slot w_valid", w_valid, 0);
        chk("jal slot w_RegWrite", w_rw, 0);
        drive(1, 5'b00000, 1, 1); tick();
        chk("flushed halt x_valid", x_valid, 0);
        chk("flushed halt pending", hp, 0);
        drive(1, 5'b00000, 0, 1); tick();
        chk("flushed halt pending 2", hp, 0);

        // ---- older ADDI completes, HALT, younger ADD bubbled ----
        do_reset();
        drive(1, 5'b01000, 0, 0); tick();
        drive(1, 5'b00000, 0, 0); tick();
        chk("halt x_ctrl.Halt", x_ctrl.Halt, 1);
        chk("halt pending set", hp, 1);
        drive(1, 5'b11011, 0, 0); tick();
        chk("after halt bubbled", x_valid, 0);
        chk("older addi w_RegWrite", {w_valid, w_rw, w_rd}, 4'b1100);
        chk("halt not yet halted 3", hd, 0);
        tick();
        chk("halt in W w_RegWrite", {w_valid, w_rw}, 2'b10);
        chk("halt not yet halted 4", hd, 0);
        tick();
        chk("halted at +4", hd, 1);
        chk("halt still bubbling", x_valid, 0);
        tick(); tick();
        chk("halted sticky", hd, 1);
        chk("halt_pending sticky", hp, 1);

        // ---- illegal opcode: NOP mode vs trap mode ----
        do_reset();
        chk("reset clears halted", hd, 0);
        drive(1, 5'b00010, 0, 0); tick();
        chk("ill nop illegal", il, 1);
        chk("ill nop pending", hp, 0);
        chk("ill nop x_ctrl", x_ctrl, 0);
        chk("ill trap illegal", t_il, 1);
        chk("ill trap pending", t_hp, 1);
        chk("ill trap x_ctrl.Halt", t_x_ctrl.Halt, 1);
        drive(1, 5'b11011, 0, 0); tick();
        chk("ill nop continues", x_valid, 1);
        chk("ill trap bubbled", t_x_valid, 0);
        drive(0, 5'b0, 0, 0); tick();
        chk("ill trap halted +3", t_hd, 0);
        tick();
        chk("ill trap halted +4", t_hd, 1);
        chk("ill nop never halts", hd, 0);

        // ---- asynchronous reset with LD in M ----
        do_reset();
        drive(1, 5'b10001, 0, 0); tick();
        drive(0, 5'b0, 0, 0); tick();
        chk("arst pre m_MemRead", m_rd, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst m_MemRead drop", m_rd, 0);
        chk("arst valids", {x_valid, m_valid, w_valid}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("arst release valids", {x_valid, m_valid, w_valid}, 0);
        chk("arst release sticky", {hp, hd, il}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

- Pipelined control unit for the WISC-SP13 five-stage core.
- Decodes the 5-bit opcode in D and carries the control word through the ID/EX (X), EX/MEM (M) and MEM/WB (W) stage registers.
- Each stage register has a valid bit and supports stall-bubble and flush.
- Tracks halt as a sticky processor state and flags illegal opcodes, which can be trapped or treated as NOP depending on the mode parameter.

## Interface
- ILLEGAL_TRAP, 0: 1 = illegal opcode behaves as HALT with `illegal` set; 0 = illegal opcode behaves as NOP with `illegal` set.
- OPC_W, 5: opcode width. Only 5 is legal.
- ALUOP_W, 4: AluOp width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- d_valid  in  1  a valid instruction is in D this cycle.
- d_opcode  in  OPC_W  opcode of the D instruction.
- stall  in  1  hold the D instruction and insert a bubble into X.
- flush  in  1  kill the D instruction; a taken branch or jump was resolved in X.
- x_valid, m_valid, w_valid  out  1 each  stage occupancy.
- x_ctrl  out  ctrl_t  full control word of the X instruction.
- m_MemRead, m_MemWrite, m_MemToReg  out  1 each  gated by m_valid.
- w_RegWrite  out  1  gated by w_valid.
- w_RegDst  out  2  destination select.
- w_MemToReg  out  1  writeback source select.
- halt_pending  out  1  a halt is in flight; fetch must stop.
- halted  out  1  sticky; set once the halt leaves W.
- illegal  out  1  sticky; an illegal opcode was captured into X.

## Operation
- Decode is combinational from d_opcode. Every field not listed below is 0.
- HALT 00000: Halt. NOP 00001: no fields set. Illegal 00010/00011: no fields set, plus Halt if ILLEGAL_TRAP.
- J 00100: Jump.
- JR 00101: Jump, JumpR.
- JAL 00110 / JALR 00111: as J / JR, plus RegWrite, RegDst=11, AluOp=1110, AluSrc2, AluSrc3.
- ADDI/SUBI/XORI/ANDNI 01000–01011: RegWrite, AluSrc, AluOp=0100, AluSpecSel2, AluSpecSel1=opc[1:0], ImmSel=10 (0100x) or 01 (0101x).
- Branches 01100–01111: Branch, AluOp=0110/0111/1000/1001 respectively.
- ST 10000: MemWrite, AluSrc, AluOp=0100, ImmSel=10, AluSpecSel2.
- LD 10001: as ST, but MemRead, MemToReg, RegWrite replace MemWrite.
- STU 10011: ST plus RegWrite, RegDst=01.
- SLBI 10010: RegDst=01, RegWrite, AluSrc, AluOp=0010, SLBIExt.
- Shift-immediates 10100–10111: RegWrite, AluSrc, AluOp=0101, ImmSel=11, AluSpecSel2, AluSpecSel1=opc[1:0].
- LBI 11000: RegDst=01, RegWrite, AluSrc, AluOp=0001.
- R-type 11001–11111: RegDst=10, RegWrite, AluOp=0011/0101/0100/1011/1100/1101/1010 respectively.
- Capture into X: X captures the D control word with x_valid=1 iff d_valid & !stall & !flush & !halt_pending. Otherwise X gets a bubble: valid=0, all fields 0.
- M and W always advance: X→M, M→W. They are never stalled.
- Valid gating: every output field is forced to 0 when its stage valid bit is 0.
- halt_pending is set when a Halt word is captured into X. It clears only on reset.
- halted is set on the cycle after a valid Halt sits in W. It is sticky.
- illegal is set when an illegal opcode is captured into X. It is sticky.

## Timing
- Reset: all valid bits, all stage fields, halt_pending, halted and illegal = 0. Reset asserted mid-operation clears in-flight instructions immediately.
- Latency: the D instruction appears on x_* 1 cycle after capture, on m_* after 2 cycles, on w_* after 3 cycles.
- flush has priority over stall. stall+flush gives a bubble into X; the D instruction is discarded.
- flush never affects X, M or W; the branch that flushes is the older instruction.
- A halt that is flushed in D does not set halt_pending.
- Back-to-back stalls produce one bubble per cycle. Instructions already in X, M and W drain normally.
- Instructions after a halt are bubbled. Instructions older than the halt complete.
- Throughput is 1 instruction/cycle when stall=flush=0.

## Structure
- Package `ctrl_pkg`:
  - opcode localparams (OPC_HALT, OPC_NOP, OPC_J, …, OPC_SCO);
  - packed struct `ctrl_t` with the 17 control fields;
  - CTRL_ZERO constant.
- Sub-module `ctrl_decode`: purely combinational, maps opcode and ILLEGAL_TRAP to {ctrl_t, illegal}.
- `ctrl_pipe` holds the three stage registers, the valid bits and the sticky halt/illegal state.

## Test plan
- Reset then ADDI (01000) in D with d_valid=1 → next cycle x_valid=1, x_ctrl AluOp=0100, ImmSel=10, AluSrc=1, RegWrite=1. At +3 cycles, w_RegWrite=1 and w_RegDst=00.
- LD 10001 followed by stall=1 for one cycle → X holds a bubble (x_valid=0) for 1 cycle. The LD reaches m_MemRead=1 at +2 cycles. The stalled instruction enters X the following cycle.
- Branch 01100 in X with flush=1 while JAL is in D → JAL never appears (x_valid=0 next cycle). w_RegWrite stays 0 for the JAL slot.
- HALT in D, then ADD (11011) on d_valid → halt_pending=1 after 1 cycle and ADD is bubbled. halted=1 at +4 cycles and stays 1 until rst.
- Opcode 00010: with ILLEGAL_TRAP=0 → illegal=1, pipeline continues. With ILLEGAL_TRAP=1 → illegal=1, halt_pending=1, halted at +4 cycles.
- rst asserted while LD occupies M → m_MemRead drops to 0 asynchronously. All valid bits are 0 after release.
